// File: rtl/time_tx_pkg.sv
// Shared definitions for the duration-transmit path: FSM encoding, the sync
// byte that optionally leads each frame, and the default UART bit period.
package time_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_DONE
  } txState_t;

  localparam logic [7:0] SYNC_BYTE            = 8'hA5;
  localparam int         DEFAULT_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud

  // Whole bytes needed to carry a value of the given bit width.
  function automatic int bytesFor(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: one-cycle bitTick every CLKS_PER_BIT clocks, with the
// count forced back to zero on the edge a new frame is accepted.
module uart_baud_tick
  import time_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bitTick
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] baudCnt;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baudCnt <= '0;
    end else if (restart || baudCnt == LAST_CNT) begin
      baudCnt <= '0;
    end else begin
      baudCnt <= baudCnt + 1'b1;
    end
  end

  assign bitTick = (baudCnt == LAST_CNT);

endmodule

// File: rtl/time_duration_uart_tx.sv
// Captures the measured duration on send and shifts it out as 8N1 bytes, MSB
// byte first. Define TIME_TX_HEADER_EN to prefix each frame with SYNC_BYTE.
module time_duration_uart_tx
  import time_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_WIDTH   = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  send,
  input  logic [DATA_WIDTH-1:0] timeDuration,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int NUM_BYTES = bytesFor(DATA_WIDTH);
  localparam int PAD_W     = NUM_BYTES * 8;
`ifdef TIME_TX_HEADER_EN
  localparam int HDR_BYTES = 1;
`else
  localparam int HDR_BYTES = 0;
`endif
  localparam int FRAME_BYTES = NUM_BYTES + HDR_BYTES;
  localparam int FRAME_W     = FRAME_BYTES * 8;
  localparam int IDX_W       = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_BYTE_IDX = IDX_W'(FRAME_BYTES - 1);

  txState_t           state, stateNext;
  logic [FRAME_W-1:0] frameReg, frameNext, frameLoad;
  logic [IDX_W-1:0]   byteIdx, byteIdxNext;
  logic [2:0]         bitIdx, bitIdxNext, bitIdxInc;
  logic [7:0]         curByte;
  logic               txNext, busyNext, doneNext;
  logic               startFrame, bitTick;

  // Zero-extension keeps the pad bits above DATA_WIDTH at 0.
`ifdef TIME_TX_HEADER_EN
  assign frameLoad = {SYNC_BYTE, PAD_W'(timeDuration)};
`else
  assign frameLoad = PAD_W'(timeDuration);
`endif

  // The byte on the wire always sits in the top 8 bits of the frame register.
  assign curByte   = frameReg[FRAME_W-1 -: 8];
  assign bitIdxInc = bitIdx + 3'd1;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) baudTick (
    .clk    (clk),
    .rst    (rst),
    .restart(startFrame),
    .bitTick(bitTick)
  );

  // NOTE: the frame register is reset too, so no X can reach tx after a mid-frame reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      frameReg <= '0;
      byteIdx  <= '0;
      bitIdx   <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= stateNext;
      frameReg <= frameNext;
      byteIdx  <= byteIdxNext;
      bitIdx   <= bitIdxNext;
      tx       <= txNext;
      busy     <= busyNext;
      done     <= doneNext;
    end
  end

  // Outputs are computed from the next state and registered, so the TX pin is glitch-free.
  always_comb begin
    // NOTE: every variable gets a default first so no branch can infer a latch.
    stateNext   = state;
    frameNext   = frameReg;
    byteIdxNext = byteIdx;
    bitIdxNext  = bitIdx;
    txNext      = 1'b1;
    startFrame  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (send) begin
          stateNext   = ST_START;
          frameNext   = frameLoad;
          byteIdxNext = LAST_BYTE_IDX;
          bitIdxNext  = '0;
          txNext      = 1'b0;
          startFrame  = 1'b1;
        end
      end

      ST_START: begin
        txNext = 1'b0;
        if (bitTick) begin
          stateNext = ST_DATA;
          txNext    = curByte[bitIdx];
        end
      end

      ST_DATA: begin
        txNext = curByte[bitIdx];
        if (bitTick) begin
          bitIdxNext = bitIdxInc;
          if (bitIdx == 3'd7) begin
            stateNext = ST_STOP;
            txNext    = 1'b1;
          end else begin
            txNext = curByte[bitIdxInc];
          end
        end
      end

      ST_STOP: begin
        if (bitTick) begin
          if (byteIdx == '0) begin
            stateNext = ST_DONE;
          end else begin
            stateNext   = ST_START;
            byteIdxNext = byteIdx - 1'b1;
            frameNext   = frameReg << 8;
            txNext      = 1'b0;
          end
        end
      end

      ST_DONE: begin
        stateNext = ST_IDLE;
      end

      default: begin
        stateNext = ST_IDLE;
      end
    endcase

    busyNext = (stateNext == ST_START) || (stateNext == ST_DATA) || (stateNext == ST_STOP);
    doneNext = (stateNext == ST_DONE);
  end

endmodule

// File: tb/tb_time_duration_uart_tx.sv
// Directed plus randomized bench for time_duration_uart_tx; expected line
// activity comes from a bit-list model of 8N1 framing.
module tb_time_duration_uart_tx;

  localparam int CPB  = 4;
  localparam int DW   = 26;
  localparam int NONE = -10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          send = 1'b0;
  logic [DW-1:0] timeDuration = '0;
  logic          tx, busy, done;

  int checks = 0;
  int errors = 0;
  bit expBits[$];

  time_duration_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .send        (send),
    .timeDuration(timeDuration),
    .tx          (tx),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Compares {tx, busy, done} against the expected triple.
  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: {tx,busy,done} observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Line levels, one entry per bit period: optional sync byte, then the
  // value as 4 bytes MSB-first, each as start, 8 data bits LSB-first, stop.
  task automatic buildModel(input logic [DW-1:0] value);
    logic [31:0] word;
    logic [7:0]  byteList[$];
    word = 32'(value);
    expBits.delete();
`ifdef TIME_TX_HEADER_EN
    byteList.push_back(8'hA5);
`endif
    for (int b = 3; b >= 0; b--) byteList.push_back(word[b*8 +: 8]);
    foreach (byteList[k]) begin
      expBits.push_back(1'b0);
      for (int i = 0; i < 8; i++) expBits.push_back(byteList[k][i]);
      expBits.push_back(1'b1);
    end
  endtask

  task automatic idleCycles(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s idle %0d", name, i), {tx, busy, done}, 3'b100);
    end
  endtask

  // Requests a frame at the current negedge and checks every cycle of it,
  // the done cycle, and the idle cycle that always follows done.
  task automatic runFrame(input string name, input logic [DW-1:0] value, input int releaseAt,
                          input int pokeAt, input logic [DW-1:0] pokeVal);
    send         = 1'b1;
    timeDuration = value;
    buildModel(value);
    for (int j = 0; j < expBits.size() * CPB; j++) begin
      @(negedge clk);
      check($sformatf("%s j=%0d", name, j), {tx, busy, done}, {expBits[j / CPB], 1'b1, 1'b0});
      if (j == releaseAt) send = 1'b0;
      if (j == pokeAt) begin
        send         = 1'b1;
        timeDuration = pokeVal;
      end
      if (j == pokeAt + 1) send = 1'b0;
    end
    @(negedge clk);
    check({name, " done"}, {tx, busy, done}, 3'b101);
    @(negedge clk);
    check({name, " after done"}, {tx, busy, done}, 3'b100);
  endtask

  initial begin
    logic [DW-1:0] rv, pv;

    // Reset is asynchronous: outputs settle before the first clock edge.
    #1 rst = 1'b1;
    #1 check("reset async", {tx, busy, done}, 3'b100);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idleCycles("post reset", 3);

    // Single request.
    runFrame("basic", 26'h2ABCDEF, 0, NONE, '0);
    idleCycles("basic quiet", 5);

    // Request and data change while busy are ignored.
    runFrame("ignore", 26'h2ABCDEF, 0, 50, '0);
    idleCycles("ignore no 2nd", 12);

    // send held: back-to-back frames separated by done and one idle cycle.
    runFrame("held a", 26'h3FFFFFF, NONE, NONE, '0);
    runFrame("held b", 26'h3FFFFFF, 100, NONE, '0);
    idleCycles("held quiet", 5);

    // Reset in the middle of a data bit that is low on the line.
    send         = 1'b1;
    timeDuration = 26'h2ABCDEF;
    buildModel(timeDuration);
    for (int j = 0; j <= 70; j++) begin
      @(negedge clk);
      check($sformatf("midrst j=%0d", j), {tx, busy, done}, {expBits[j / CPB], 1'b1, 1'b0});
      if (j == 0) send = 1'b0;
    end
    #2 rst = 1'b1;
    #1 check("midrst async", {tx, busy, done}, 3'b100);
    @(negedge clk);
    rst = 1'b0;
    idleCycles("midrst abandoned", 50);
    runFrame("midrst fresh", 26'h2ABCDEF, 0, NONE, '0);

    runFrame("zero", '0, 0, NONE, '0);

    // Random values, gaps and ignored mid-frame requests.
    for (int r = 0; r < 4; r++) begin
      rv = DW'($urandom);
      pv = DW'($urandom);
      idleCycles($sformatf("rand%0d gap", r), int'($urandom_range(0, 4)));
      runFrame($sformatf("rand%0d", r), rv, 0, int'($urandom_range(1, 150)), pv);
    end

    // Smallest non-zero value; with the header build the frame grows to 5 bytes.
    runFrame("one", 26'h0000001, 0, NONE, '0);
    idleCycles("final", 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
